// File: rtl/sniffer_pkg.sv
// sniffer_pkg: shared types and constants for the LPC sniffer capture-record path.
// Holds the serializer state encoding, the sequence-number width, the status
// byte layout and the default frame sync byte.
package sniffer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SYNC,
        STATUS,
        DATA,
        CSUM,
        DONE
    } state_e;

    localparam int SEQ_W = 7;

    // Status byte layout: overflow flag on top, frame sequence number below it
    localparam int STATUS_OVF_BIT = 7;
    localparam int STATUS_SEQ_MSB = 6;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    function automatic logic [7:0] make_status(input logic ovf, input logic [SEQ_W-1:0] seq);
        logic [7:0] s;
        s = 8'h00;
        s[STATUS_OVF_BIT] = ovf;
        s[STATUS_SEQ_MSB:0] = seq;
        return s;
    endfunction

endpackage

// File: rtl/record_serializer_byte_mux_shift.sv
// byte_mux_shift: picks byte number index_i of a latched capture record.
// Index 0 is the most significant byte unless LSB_FIRST is set, in which case
// index 0 is the least significant byte.
module byte_mux_shift
    import sniffer_pkg::*;
#(
    parameter int DW = 48,
    parameter bit LSB_FIRST = 1'b0,
    localparam int NB = DW / 8,
    localparam int IW = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic [DW-1:0] record_i,
    input  logic [IW-1:0] index_i,
    output logic [7:0]    byte_o
);

    logic [IW-1:0] sel;
    logic [DW-1:0] shifted;

    // Convert the transmit index into a byte lane and shift that lane to the bottom
    always_comb begin
        sel     = LSB_FIRST ? index_i : (IW'(NB - 1) - index_i);
        shifted = record_i >> {sel, 3'b000};
        byte_o  = shifted[7:0];
    end

endmodule

// File: rtl/record_serializer.sv
// record_serializer: pops capture records from the ring buffer and streams each
// one to uart_tx as a frame of sync byte, status byte and DW/8 data bytes.
// Optional trailing checksum byte is built when RECORD_SERIALIZER_CHECKSUM_EN is
// defined; the default build ends each frame after the last data byte.
module record_serializer
    import sniffer_pkg::*;
#(
    parameter int         DW        = 48,
    parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE,
    parameter bit         LSB_FIRST = 1'b0
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          read_empty,
    output logic          read_clock_enable,
    input  logic [DW-1:0] read_data,
    input  logic          overflow,
    input  logic          uart_ready,
    output logic [7:0]    uart_data,
    output logic          uart_clock_enable,
    output logic          busy
);

    localparam int NB = DW / 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

    state_e            state_q;
    logic [SEQ_W-1:0]  seq_q;
    logic              ovf_q;
    logic [IW-1:0]     idx_q;
    logic [DW-1:0]     rec_q;
    logic [7:0]        data_q;
    logic              uce_prev_q;
`ifdef RECORD_SERIALIZER_CHECKSUM_EN
    logic [7:0]        acc_q;
`endif

    logic       issue_ok;
    logic       rce_raw;
    logic       uce_raw;
    logic [7:0] tx_byte_d;
    logic [7:0] status_byte;
    logic [7:0] mux_byte;

    byte_mux_shift #(
        .DW        (DW),
        .LSB_FIRST (LSB_FIRST)
    ) u_byte_mux (
        .record_i (rec_q),
        .index_i  (idx_q),
        .byte_o   (mux_byte)
    );

    // A byte may only go out when the UART is idle and we did not strobe last
    // cycle, since uart_ready only drops one cycle after the strobe.
    assign issue_ok    = uart_ready && !uce_prev_q;
    assign status_byte = make_status(ovf_q, seq_q);

    // Decide this cycle's pop and transmit strobes and the byte that goes out
    always_comb begin
        rce_raw   = 1'b0;
        uce_raw   = 1'b0;
        tx_byte_d = data_q;
        case (state_q)
            IDLE: begin
                rce_raw = !read_empty;
            end
            SYNC: begin
                uce_raw   = issue_ok;
                tx_byte_d = SYNC_BYTE;
            end
            STATUS: begin
                uce_raw   = issue_ok;
                tx_byte_d = status_byte;
            end
            DATA: begin
                uce_raw   = issue_ok;
                tx_byte_d = mux_byte;
            end
`ifdef RECORD_SERIALIZER_CHECKSUM_EN
            CSUM: begin
                uce_raw   = issue_ok;
                tx_byte_d = 8'h00 - acc_q;
            end
`endif
            default: begin
            end
        endcase
    end

    // Strobes are forced low while reset is held so an abort silences the UART at once
    assign read_clock_enable = rce_raw & reset;
    assign uart_clock_enable = uce_raw & reset;
    assign uart_data         = uart_clock_enable ? tx_byte_d : data_q;
    assign busy              = (state_q != IDLE);

    // Frame sequencer: one pop, then sync/status/data bytes, then sequence bump
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            seq_q      <= '0;
            ovf_q      <= 1'b0;
            idx_q      <= '0;
            rec_q      <= '0;
            data_q     <= 8'h00;
            uce_prev_q <= 1'b0;
`ifdef RECORD_SERIALIZER_CHECKSUM_EN
            acc_q      <= 8'h00;
`endif
        end else begin
            uce_prev_q <= uart_clock_enable;
            if (uart_clock_enable) begin
                data_q <= tx_byte_d;
            end

            if (overflow) begin
                ovf_q <= 1'b1;
            end else if (state_q == STATUS && uart_clock_enable) begin
                ovf_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (!read_empty) begin
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    rec_q   <= read_data;
                    idx_q   <= '0;
`ifdef RECORD_SERIALIZER_CHECKSUM_EN
                    acc_q   <= 8'h00;
`endif
                    state_q <= SYNC;
                end
                SYNC: begin
                    if (uart_clock_enable) begin
                        state_q <= STATUS;
                    end
                end
                STATUS: begin
                    if (uart_clock_enable) begin
`ifdef RECORD_SERIALIZER_CHECKSUM_EN
                        acc_q <= acc_q + status_byte;
`endif
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (uart_clock_enable) begin
`ifdef RECORD_SERIALIZER_CHECKSUM_EN
                        acc_q <= acc_q + mux_byte;
`endif
                        if (idx_q == LAST_IDX) begin
                            idx_q <= '0;
`ifdef RECORD_SERIALIZER_CHECKSUM_EN
                            state_q <= CSUM;
`else
                            state_q <= DONE;
`endif
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end
                end
`ifdef RECORD_SERIALIZER_CHECKSUM_EN
                CSUM: begin
                    if (uart_clock_enable) begin
                        state_q <= DONE;
                    end
                end
`endif
                DONE: begin
                    seq_q   <= seq_q + SEQ_W'(1);
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/record_serializer.md
Name: record_serializer

Overview:
- Parametrised successor to the fixed 48-bit ring-buffer-to-UART path in the LPC sniffer.
- Pops DW-bit capture records from the ring buffer.
- Frames each record as: sync byte, status byte, NB data bytes, optional checksum.
- Feeds the frame byte-by-byte to uart_tx. Sits between ringbuffer and uart_tx on the ext_clock domain.

Parameters:
- DW, 48, record width in bits; must be a multiple of 8, range 8..128; NB = DW/8.
- SYNC_BYTE, 8'hA5, first byte of every frame.
- LSB_FIRST, 0, 0 = data bytes sent MSB byte first; 1 = LSB byte first.

Ports:
- clock  in  1  system clock (ext_clock domain).
- reset  in  1  asynchronous, active-low reset.
- read_empty  in  1  ring buffer empty.
- read_clock_enable  out  1  one-cycle pop strobe to ring buffer.
- read_data  in  DW  ring buffer head record; valid the cycle after a read_clock_enable pulse.
- overflow  in  1  ring buffer overflow level.
- uart_ready  in  1  uart_tx idle. Contract: low from the cycle after a strobe until that byte completes.
- uart_data  out  8  byte to transmit.
- uart_clock_enable  out  1  one-cycle transmit strobe.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: read_clock_enable=0, uart_clock_enable=0, uart_data=0, busy=0.
  - State=IDLE, seq=0, ovf_sticky=0, byte index=0, checksum=0.
- Overflow tracking: ovf_sticky is set in any cycle overflow=1. It is cleared in the cycle the status byte is strobed, unless overflow=1 in that same cycle; then it stays set.
- IDLE: if read_empty=0, pulse read_clock_enable for 1 cycle and go to FETCH. Otherwise stay.
- FETCH: 1 cycle. Latch read_data into the shift register and go to SYNC.
- SYNC, STATUS, DATA: each byte is issued in a cycle where uart_ready=1 and uart_clock_enable was 0 in the previous cycle. This guarantees no double-issue before ready falls.
  - SYNC: issue SYNC_BYTE, then go to STATUS.
  - STATUS: issue {ovf_sticky, seq[6:0]}, then go to DATA.
  - DATA: issue bytes in the LSB_FIRST order; the index runs 0..NB-1. After byte NB-1, go to CSUM (if enabled) or DONE.
- DONE: 1 cycle.
  - seq increments modulo 128 (127 wraps to 0).
  - Return to IDLE.
  - A non-empty buffer at DONE gives a pop on the next IDLE cycle, so back-to-back frames lose no records.
- uart_data holds the last issued byte between strobes.
- Latencies:
  - Pop strobe to first uart_clock_enable: minimum 2 cycles (pop, FETCH, strobe).
  - Minimum frame length: NB+2 strobes (NB+3 with checksum).
- Boundary conditions:
  - read_empty may rise or fall mid-frame; it is ignored outside IDLE.
  - Exactly one pop per frame.
  - Reset mid-frame aborts immediately: no further strobes, and a partially sent frame is not resumed.
  - An uart_ready glitch high while uart_clock_enable was high in the previous cycle is ignored.

Optional Feature:
- Macro: RECORD_SERIALIZER_CHECKSUM_EN.
- Defined:
  - Adds a CSUM state after DATA.
  - An 8-bit accumulator is cleared in FETCH and sums the status byte and all data bytes, modulo 256.
  - CSUM issues the two's complement of the accumulator, so status + data + checksum = 0 mod 256. Then go to DONE.
- Undefined:
  - No CSUM state and no accumulator logic.
  - The frame ends after the last data byte.

Decomposition:
- Shared package sniffer_pkg holds:
  - State enum: IDLE, FETCH, SYNC, STATUS, DATA, CSUM, DONE.
  - SEQ_W=7.
  - Status byte field positions: bit7 ovf, bits6:0 seq.
  - Default SYNC_BYTE.
- One natural sub-module: byte_mux_shift. It selects byte[index] of the latched record, honouring LSB_FIRST.
- The FSM, counters and handshake stay in record_serializer.

Test Plan:
- Single record, DW=48, read_data=48'h0011_2233_4455, uart_ready tied high between bytes → bytes A5, 00, 00, 11, 22, 33, 44, 55; exactly 1 pop; seq=1 after DONE.
- Same record with LSB_FIRST=1 → A5, 00, 55, 44, 33, 22, 11, 00.
- Overflow pulse of 1 cycle while idle, then 2 records → first status byte 0x80|seq=0x80, second status byte 0x01.
- 130 back-to-back records with the buffer never empty → status seq runs 0..127, then 0, 1; no gap beyond FETCH and DONE between frames; pop count = 130.
- With RECORD_SERIALIZER_CHECKSUM_EN, DW=16, data=16'h01FF, seq=0, ovf=0 → A5, 00, 01, FF, 00 (sum 0x100 → 0x00, complement 0x00). Data 16'h0102 → checksum FD.
- Assert reset after the third byte strobe → uart_clock_enable stays 0, busy=0 immediately. After release with the buffer non-empty, a new frame starts with A5 and seq=0.
